// File: rtl/transfer_receiver_pkg.sv
// Shared definitions for the dual-scanner transfer interface.
// Used by the receiver, the scanner side and the display logic.
//   xfer_state_t : FSM state encoding (also driven out on the debug state port)
//   DEF_*        : default DATA_W / XFER_LEN / FIFO_DEPTH values
package transfer_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQUEST = 2'b01,
    RECEIVE = 2'b10,
    DONE    = 2'b11
  } xfer_state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_XFER_LEN   = 10;
  localparam int DEF_FIFO_DEPTH = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clk, reset(async, active-low)
//   wr_en/wr_data : push (caller guarantees space)
//   rd_en         : pop head; ignored when empty (sets sticky underflow)
//   rd_data       : head entry, combinational, don't-care when empty
//   count, empty, underflow : status
module sync_fifo
  import transfer_receiver_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_underflow;
  logic              w_pop;

  assign w_pop     = rd_en && (r_count != '0);
  assign rd_data   = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign empty     = (r_count == '0);
  assign underflow = r_underflow;

  // Storage needs no reset: entries are only observed once written.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of 2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({wr_en, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (rd_en && (r_count == '0)) r_underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/transfer_receiver.sv
// Host-side collector for two scanners. Round-robin arbitrates ready0/ready1,
// pulses start_transferN for one cycle, captures an XFER_LEN-byte burst from
// the chosen scanner into a show-ahead FIFO drained by the consumer.
//   clk, reset(async, active-low)
//   ready0/1, data_in0/1       : scanner side
//   start_transfer0/1          : one-cycle start pulse
//   active_scanner, busy, xfer_done, state : status/debug
//   rd_en, rd_data, rd_valid, fifo_count, underflow : consumer side
module transfer_receiver
  import transfer_receiver_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int XFER_LEN   = DEF_XFER_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready0,
  input  logic              ready1,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  output logic              start_transfer0,
  output logic              start_transfer1,
  output logic              active_scanner,
  output logic              busy,
  output logic              xfer_done,
  output logic [1:0]        state,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              underflow
);

  localparam int BEAT_W = $clog2(XFER_LEN + 1);

  xfer_state_t       r_state;
  logic              r_active;
  logic              r_rr;       // scanner favoured when both are ready
  logic [BEAT_W-1:0] r_beat;
  logic              r_start0, r_start1, r_done, r_busy;

  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_push;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_space_ok;
  logic              w_win;

  // Admit a burst only if the whole thing fits, so the FIFO can never overflow.
  assign w_space_ok = (CNT_W'(FIFO_DEPTH) - w_count) >= CNT_W'(XFER_LEN);
  assign w_win      = (ready0 && ready1) ? r_rr : ready1;
  assign w_push     = (r_state == RECEIVE);
  assign w_wr_data  = r_active ? data_in1 : data_in0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_active <= 1'b0;
      r_rr     <= 1'b0;
      r_beat   <= '0;
      r_start0 <= 1'b0;
      r_start1 <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_start0 <= 1'b0;
      r_start1 <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if ((ready0 || ready1) && w_space_ok) begin
            r_state  <= REQUEST;
            r_active <= w_win;
            r_start0 <= ~w_win;
            r_start1 <= w_win;
            r_busy   <= 1'b1;
          end
        end
        REQUEST: begin
          r_state <= RECEIVE;
          r_beat  <= '0;
        end
        RECEIVE: begin
          if (r_beat == BEAT_W'(XFER_LEN - 1)) begin
            r_beat  <= '0;
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_beat <= r_beat + BEAT_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_rr    <= ~r_active;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (w_push),
    .wr_data   (w_wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .count     (w_count),
    .empty     (w_empty),
    .underflow (underflow)
  );

  assign start_transfer0 = r_start0;
  assign start_transfer1 = r_start1;
  assign active_scanner  = r_active;
  assign busy            = r_busy;
  assign xfer_done       = r_done;
  assign state           = r_state;
  assign rd_valid        = ~w_empty;
  assign fifo_count      = w_count;

endmodule

// File: tb/tb_transfer_receiver.sv
// Self-checking bench: a transaction-timeline model (phase counter + byte
// queue) predicts every output each cycle; directed literal checks pin the
// model on the scenarios of interest, then a randomized run follows.
module tb_transfer_receiver;

  localparam int DW = 8;
  localparam int L  = 10;
  localparam int D  = 16;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          ready0, ready1, rd_en;
  logic [DW-1:0] data_in0, data_in1;
  logic          start_transfer0, start_transfer1, active_scanner, busy, xfer_done;
  logic [1:0]    state;
  logic [DW-1:0] rd_data;
  logic          rd_valid, underflow;
  logic [CW-1:0] fifo_count;

  transfer_receiver #(.DATA_W(DW), .XFER_LEN(L), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ready0(ready0), .ready1(ready1),
    .data_in0(data_in0), .data_in1(data_in1),
    .start_transfer0(start_transfer0), .start_transfer1(start_transfer1),
    .active_scanner(active_scanner), .busy(busy), .xfer_done(xfer_done),
    .state(state), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(fifo_count), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;
  bit rnd_data = 1'b0;

  // Model: m_ph = -1 idle, 0 request cycle, 1..L receive beats, L+1 done cycle.
  int            m_ph;
  bit            m_act, m_prio, m_uf;
  logic [DW-1:0] m_q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ph = -1; m_act = 1'b0; m_prio = 1'b0; m_uf = 1'b0;
    m_q.delete();
  endtask

  task automatic m_step();
    int n;
    n = m_q.size();
    if (rd_en) begin
      if (n == 0) m_uf = 1'b1;
      else void'(m_q.pop_front());
    end
    if (m_ph >= 1 && m_ph <= L) m_q.push_back(m_act ? data_in1 : data_in0);
    if (m_ph < 0) begin
      if ((ready0 || ready1) && (D - n) >= L) begin
        m_act = (ready0 && ready1) ? m_prio : ready1;
        m_ph  = 0;
      end
    end else if (m_ph == L + 1) begin
      m_prio = !m_act;
      m_ph   = -1;
    end else begin
      m_ph++;
    end
  endtask

  function automatic logic [1:0] exp_state();
    if (m_ph < 0)  return 2'd0;
    if (m_ph == 0) return 2'd1;
    if (m_ph <= L) return 2'd2;
    return 2'd3;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state", state, exp_state());
      chk("start0", start_transfer0, (m_ph == 0) && !m_act);
      chk("start1", start_transfer1, (m_ph == 0) && m_act);
      chk("active", active_scanner, m_act);
      chk("busy", busy, m_ph >= 0);
      chk("xfer_done", xfer_done, m_ph == L + 1);
      chk("rd_valid", rd_valid, m_q.size() != 0);
      chk("fifo_count", fifo_count, m_q.size());
      chk("underflow", underflow, m_uf);
      if (m_q.size() != 0) chk("rd_data", rd_data, m_q[0]);
    end
  end

  // One clock: model follows the DUT edge, then drive data for the next edge.
  task automatic tick();
    int beat;
    @(posedge clk);
    if (reset) m_step();
    #1;
    beat = (m_ph >= 1 && m_ph <= L) ? m_ph - 1 : 0;
    if (rnd_data) begin
      data_in0 = DW'($urandom);
      data_in1 = DW'($urandom);
    end else begin
      data_in0 = DW'(8'h10 + beat);
      data_in1 = DW'(8'hB0 + beat);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_reset();
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ord[$];
    logic [DW-1:0] got[$];
    int n_s0, n_s1, n_done;
    bit found;

    reset = 1'b0; ready0 = 1'b1; ready1 = 1'b1; rd_en = 1'b0;
    data_in0 = 8'h10; data_in1 = 8'hB0;
    m_reset();
    cmp_en = 1'b1;

    // Reset with both ready high.
    repeat (3) tick();
    chk("rst_state", state, 2'b00);
    chk("rst_count", fifo_count, 0);
    chk("rst_start", {start_transfer0, start_transfer1}, 2'b00);
    chk("rst_valid", rd_valid, 0);
    chk("rst_uflow", underflow, 0);

    // Single burst from scanner 0.
    ready1 = 1'b0; reset = 1'b1;
    n_s0 = 0; n_s1 = 0; n_done = 0;
    repeat (14) begin
      tick();
      n_s0 += int'(start_transfer0);
      n_s1 += int'(start_transfer1);
      n_done += int'(xfer_done);
      if (start_transfer0) ready0 = 1'b0;
    end
    chk("s2_start0_cnt", n_s0, 1);
    chk("s2_start1_cnt", n_s1, 0);
    chk("s2_done_cnt", n_done, 1);
    chk("s2_count", fifo_count, 10);
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("s2_pop_data", rd_data, 8'h10 + i);
      tick();
    end
    rd_en = 1'b0;
    chk("s2_empty", fifo_count, 0);

    // Both ready, FIFO drained every cycle: round-robin 0,1,0,1.
    do_reset();
    ready0 = 1'b1; ready1 = 1'b1; rd_en = 1'b1;
    repeat (60) begin
      tick();
      if (start_transfer0) ord.push_back(0);
      if (start_transfer1) ord.push_back(1);
    end
    chk("s3_nstarts", ord.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      if (i < ord.size()) chk("s3_rr_order", ord[i], i % 2);
    ready0 = 1'b0; ready1 = 1'b0;
    repeat (16) tick();
    rd_en = 1'b0;

    // Backpressure: 10 queued, scanner 1 waits until 4 pops free space.
    do_reset();
    ready1 = 1'b1;
    repeat (14) tick();
    chk("s4_count", fifo_count, 10);
    repeat (8) begin
      tick();
      chk("s4_bp_start1", start_transfer1, 0);
      chk("s4_bp_state", state, 2'b00);
    end
    rd_en = 1'b1;
    repeat (4) tick();
    rd_en = 1'b0;
    chk("s4_count6", fifo_count, 6);
    chk("s4_no_start_yet", start_transfer1, 0);
    tick();
    chk("s4_start1_fires", start_transfer1, 1);
    ready1 = 1'b0;
    repeat (13) tick();
    rd_en = 1'b1;
    repeat (20) tick();
    rd_en = 1'b0;

    // Read every cycle during a burst into an empty FIFO.
    do_reset();
    ready0 = 1'b1; rd_en = 1'b1;
    repeat (16) begin
      tick();
      chk("s5_cnt_le1", fifo_count <= 1, 1);
      if (rd_valid) got.push_back(rd_data);
      if (start_transfer0) ready0 = 1'b0;
    end
    chk("s5_nbytes", got.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < got.size()) chk("s5_order", got[i], 8'h10 + i);
    chk("s5_uflow", underflow, 1);
    rd_en = 1'b0;
    repeat (3) tick();
    chk("s5_uflow_sticky", underflow, 1);

    // Reset in the middle of a burst.
    do_reset();
    ready0 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (start_transfer0) ready0 = 1'b0;
      if (m_q.size() == 5) found = 1'b1;
    end
    chk("s6_reached_beat5", found, 1);
    reset = 1'b0;
    m_reset();
    #1;
    chk("s6_rst_state", state, 2'b00);
    chk("s6_rst_count", fifo_count, 0);
    chk("s6_rst_busy", busy, 0);
    tick();
    tick();
    reset = 1'b1; ready0 = 1'b1;
    repeat (14) begin
      tick();
      if (start_transfer0) ready0 = 1'b0;
    end
    chk("s6_fresh_count", fifo_count, 10);
    chk("s6_fresh_head", rd_data, 8'h10);
    rd_en = 1'b1;
    repeat (12) tick();
    rd_en = 1'b0;

    // Randomized traffic.
    do_reset();
    rnd_data = 1'b1;
    repeat (800) begin
      tick();
      ready0 = 1'($urandom_range(0, 1));
      ready1 = 1'($urandom_range(0, 1));
      rd_en  = ($urandom_range(0, 3) != 0);
    end
    rd_en = 1'b0;
    tick();

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
